// File: rtl/key_event_decoder.sv
// Single-key gesture classifier: turns press pulses and the held level into click,
// double-click and long-press events, and steers the LCD test-pattern index from them.
module key_event_decoder #(
    parameter int unsigned T_DBL   = 31_250_000,
    parameter int unsigned T_LONG  = 125_000_000,
    parameter int unsigned T_AUTO  = 250_000_000,
    parameter int unsigned NUM_PAT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       press_pulse,
    input  logic       key_held,
    output logic [3:0] pat_idx,
    output logic       auto_mode,
    output logic       evt_single,
    output logic       evt_double,
    output logic       evt_long
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_LHOLD,
        S_WAIT2,
        S_RELWAIT
    } state_t;

    localparam logic [31:0] DBL_LAST  = 32'(T_DBL - 1);
    localparam logic [31:0] LONG_LAST = 32'(T_LONG - 1);
    localparam logic [31:0] AUTO_LAST = 32'(T_AUTO - 1);
    localparam logic [3:0]  PAT_LAST  = 4'(NUM_PAT - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] auto_cnt_q, auto_cnt_d;
    logic [3:0]  pat_q, pat_d;
    logic        auto_q, auto_d;
    logic        evt_single_q, evt_single_d;
    logic        evt_double_q, evt_double_d;
    logic        evt_long_q, evt_long_d;

    function automatic logic [3:0] pat_inc(input logic [3:0] p);
        return (p == PAT_LAST) ? 4'd0 : p + 4'd1;
    endfunction

    function automatic logic [3:0] pat_dec(input logic [3:0] p);
        return (p == 4'd0) ? PAT_LAST : p - 4'd1;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        auto_cnt_d   = 32'd0;  // any cycle not counting in IDLE restarts the auto period
        pat_d        = pat_q;
        auto_d       = auto_q;
        evt_single_d = 1'b0;
        evt_double_d = 1'b0;
        evt_long_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (press_pulse) begin
                    state_d = S_PRESSED;
                    cnt_d   = 32'd0;
                end else if (auto_q) begin
                    if (auto_cnt_q == AUTO_LAST) begin
                        pat_d = pat_inc(pat_q);
                    end else begin
                        auto_cnt_d = auto_cnt_q + 32'd1;
                    end
                end
            end
            S_PRESSED: begin
                cnt_d = cnt_q + 32'd1;
                if (!key_held) begin
                    state_d = S_WAIT2;
                    cnt_d   = 32'd0;
                end else if (cnt_q == LONG_LAST) begin
                    evt_long_d = 1'b1;
                    auto_d     = ~auto_q;
                    state_d    = S_LHOLD;
                end
            end
            S_LHOLD: begin
                if (!key_held) state_d = S_IDLE;
            end
            S_WAIT2: begin
                cnt_d = cnt_q + 32'd1;
                // A second press beats an expiring window on the same cycle.
                if (press_pulse) begin
                    evt_double_d = 1'b1;
                    pat_d        = pat_dec(pat_q);
                    state_d      = S_RELWAIT;
                end else if (cnt_q == DBL_LAST) begin
                    evt_single_d = 1'b1;
                    pat_d        = pat_inc(pat_q);
                    state_d      = S_IDLE;
                end
            end
            S_RELWAIT: begin
                if (!key_held) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 32'd0;
            auto_cnt_q   <= 32'd0;
            pat_q        <= 4'd0;
            auto_q       <= 1'b0;
            evt_single_q <= 1'b0;
            evt_double_q <= 1'b0;
            evt_long_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            auto_cnt_q   <= auto_cnt_d;
            pat_q        <= pat_d;
            auto_q       <= auto_d;
            evt_single_q <= evt_single_d;
            evt_double_q <= evt_double_d;
            evt_long_q   <= evt_long_d;
        end
    end

    assign pat_idx    = pat_q;
    assign auto_mode  = auto_q;
    assign evt_single = evt_single_q;
    assign evt_double = evt_double_q;
    assign evt_long   = evt_long_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: stimulus pushes hand-computed expected
// observations (event, pattern, auto flag, cycle); a monitor pops one per DUT output change.
module tb_key_event_decoder;

    localparam int T_DBL   = 20;
    localparam int T_LONG  = 100;
    localparam int T_AUTO  = 50;
    localparam int NUM_PAT = 4;

    localparam logic [2:0] EV_NONE   = 3'b000;
    localparam logic [2:0] EV_SINGLE = 3'b001;
    localparam logic [2:0] EV_DOUBLE = 3'b010;
    localparam logic [2:0] EV_LONG   = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       press_pulse = 1'b0;
    logic       key_held = 1'b0;
    logic [3:0] pat_idx;
    logic       auto_mode;
    logic       evt_single;
    logic       evt_double;
    logic       evt_long;

    typedef struct {
        logic [2:0] ev;
        logic [3:0] pat;
        logic       aut;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic mon_en   = 1'b0;

    key_event_decoder #(
        .T_DBL  (T_DBL),
        .T_LONG (T_LONG),
        .T_AUTO (T_AUTO),
        .NUM_PAT(NUM_PAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .press_pulse(press_pulse),
        .key_held   (key_held),
        .pat_idx    (pat_idx),
        .auto_mode  (auto_mode),
        .evt_single (evt_single),
        .evt_double (evt_double),
        .evt_long   (evt_long)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [2:0] ev, input logic [3:0] p, input logic a, input int at);
        exp_t e;
        e.ev  = ev;
        e.pat = p;
        e.aut = a;
        e.at  = at;
        exp_q.push_back(e);
    endtask

    // Press, hold for hold_n cycles, then drop key_held; rel is the cycle the release is driven.
    task automatic press_release(input int hold_n, output int rel);
        press_pulse = 1'b1;
        key_held    = 1'b1;
        tick(1);
        press_pulse = 1'b0;
        tick(hold_n);
        key_held = 1'b0;
        rel      = cyc;
    endtask

    task automatic do_single(input logic [3:0] p, input logic a, output int at);
        int r;
        press_release(10, r);
        at = r + 1 + T_DBL;
        push(EV_SINGLE, p, a, at);
        tick(T_DBL + 3);
    endtask

    // Second press gap cycles after the release; an extra pulse lands in RELWAIT.
    task automatic do_double(input int gap, input logic [3:0] p, input logic a);
        int r;
        press_release(10, r);
        tick(gap);
        press_pulse = 1'b1;
        key_held    = 1'b1;
        push(EV_DOUBLE, p, a, cyc + 1);
        tick(1);
        press_pulse = 1'b0;
        tick(1);
        press_pulse = 1'b1;
        tick(1);
        press_pulse = 1'b0;
        tick(2);
        key_held = 1'b0;
        tick(2);
    endtask

    // Long hold with ignored pulses in PRESSED and LHOLD; rel is the release cycle.
    task automatic do_long(input logic [3:0] p, input logic a, output int rel);
        int e0;
        press_pulse = 1'b1;
        key_held    = 1'b1;
        e0          = cyc + 1;
        push(EV_LONG, p, a, e0 + T_LONG);
        tick(1);
        press_pulse = 1'b0;
        tick(29);
        press_pulse = 1'b1;
        tick(1);
        press_pulse = 1'b0;
        tick(79);
        press_pulse = 1'b1;
        tick(1);
        press_pulse = 1'b0;
        tick(39);
        key_held = 1'b0;
        rel      = cyc;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    // Monitor: one observation per cycle in which an event fires or pat/auto changes.
    initial begin
        logic [2:0] obs;
        logic [3:0] prev_pat;
        logic       prev_auto;
        exp_t       e;
        prev_pat  = 4'd0;
        prev_auto = 1'b0;
        forever begin
            @(negedge clk);
            obs = {evt_long, evt_double, evt_single};
            if (mon_en && (obs != EV_NONE || pat_idx != prev_pat || auto_mode != prev_auto)) begin
                $display("obs cycle=%0d evt=%b pat_idx=%0d auto_mode=%0b", cyc, obs, pat_idx, auto_mode);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output cycle=%0d evt=%b pat_idx=%0d auto_mode=%0b required=no output",
                             cyc, obs, pat_idx, auto_mode);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_kind", int'(obs), int'(e.ev));
                    check("pat_idx", int'(pat_idx), int'(e.pat));
                    check("auto_mode", int'(auto_mode), int'(e.aut));
                    check("evt_cycle", cyc, e.at);
                end
            end
            prev_pat  = pat_idx;
            prev_auto = auto_mode;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int s;
        int wait_n;
        tick(3);
        rst = 1'b0;
        check("reset_pat_idx", int'(pat_idx), 0);
        check("reset_auto_mode", int'(auto_mode), 0);
        check("reset_evts", int'({evt_long, evt_double, evt_single}), 0);
        mon_en = 1'b1;
        tick(2);

        do_single(4'd1, 1'b0, s);
        do_double(5, 4'd0, 1'b0);
        do_double(5, 4'd3, 1'b0);
        do_double(T_DBL, 4'd2, 1'b0);
        do_single(4'd3, 1'b0, s);
        do_single(4'd0, 1'b0, s);

        do_long(4'd0, 1'b1, r);
        for (int i = 0; i < 4; i++) begin
            push(EV_NONE, 4'((i + 1) % NUM_PAT), 1'b1, r + 1 + T_AUTO + i * T_AUTO);
        end
        tick(210);

        do_single(4'd1, 1'b1, s);
        push(EV_NONE, 4'd2, 1'b1, s + T_AUTO);
        tick(58);
        push(EV_NONE, 4'd0, 1'b0, cyc + 1);
        pulse_reset();
        tick(60);

        do_single(4'd1, 1'b0, s);
        press_release(5, r);
        tick(8);
        push(EV_NONE, 4'd0, 1'b0, cyc + 1);
        pulse_reset();
        tick(40);

        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 200) begin
            tick(1);
            wait_n++;
        end
        check("queue_drained", exp_q.size(), 0);
        check("final_pat_idx", int'(pat_idx), 0);
        check("final_auto_mode", int'(auto_mode), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
